pipe_control: RTL and testbench
===============================

# pipe_control

Parametrised pipeline control block that turns debounced board inputs into pipeline configuration. It sits between the board buttons and switches and the camera-config and filter pipeline. It generalises single-mode, two-filter control to:
- N filter switches and M modes;
- a saturating, parametrised threshold with auto-repeat on held buttons;
- frame-aligned application of filter-enable changes, so enables never change mid-frame.

## Interface
Parameters:
- NUM_FILTERS, 2, number of filter switch/enable pairs.
- NUM_MODES, 2, number of modes (≥2); mode 0 is passthrough.
- THRESH_W, 22, threshold width in bits.
- THRESH_RESET, 500000, threshold value after reset.
- THRESH_STEP, 50000, increment/decrement per step.
- THRESH_MIN, 0, lower saturation bound.
- THRESH_MAX, 2090000, upper saturation bound (< 2^THRESH_W).
- DB_COUNT, 500000, debounce period in cycles, passed to each `debounce` instance.
- REPEAT_DELAY, 25000000, hold cycles before auto-repeat starts.
- REPEAT_RATE, 5000000, cycles between auto-repeat steps.

Ports:
- i_sysclk  in  1  system clock; the only clock.
- i_rstn  in  1  reset, synchronous, active-low.
- i_sof  in  1  start-of-frame pulse, synchronous to i_sysclk.
- i_btn_mode  in  1  raw mode-advance button.
- i_btn_inc  in  1  raw threshold-increment button.
- i_btn_dec  in  1  raw threshold-decrement button.
- i_sw_filter  in  NUM_FILTERS  raw filter switches.
- o_cfg_start  out  1  camera-config start pulse.
- o_mode  out  clog2(NUM_MODES)  current mode.
- o_pipe_flush  out  1  pipeline flush request.
- o_filter_enable  out  NUM_FILTERS  applied filter enables.
- o_threshold  out  THRESH_W  threshold value.

## Operation
- Each of the three buttons and each switch goes through its own `debounce` instance (DB_COUNT), then a 2-flop edge detector.
- Config start:
  - o_cfg_start pulses high exactly one cycle, on the first clock after i_rstn deasserts.
  - It stays low after that until the next reset.
- Mode:
  - Each debounced rising edge of the mode button sets o_mode ← o_mode+1.
  - o_mode wraps from NUM_MODES−1 to 0.
- Filter enables (shadowed):
  - Target value = debounced switches, or all zeros when o_mode==0.
  - o_filter_enable loads the target only on a cycle with i_sof=1.
- Flush FSM, states IDLE and PENDING:
  - IDLE → PENDING when the target differs from o_filter_enable, or when o_mode changes.
  - PENDING → IDLE on i_sof. The enables update in that same cycle.
  - o_pipe_flush = 1 exactly while in PENDING, so it is registered high from the cycle after the change is detected through the i_sof cycle.
  - If the target returns to equal o_filter_enable while PENDING, the FSM stays PENDING until i_sof (no early exit).
- Threshold:
  - inc step: o_threshold ← min(o_threshold+STEP, MAX).
  - dec step: o_threshold ← max(o_threshold−STEP, MIN).
  - Both computed at THRESH_W+1 bits so there is no wrap-around.
- Auto-repeat:
  - A per-button hold counter starts on the debounced rising edge, which itself produces one step.
  - After REPEAT_DELAY cycles held, the button steps again, then every REPEAT_RATE cycles while still held.
  - Release clears the counter.
- Simultaneous inc and dec held: no steps occur, and both hold counters are cleared.

## Timing
- Reset values:
  - o_cfg_start=0, o_mode=0, o_pipe_flush=0, o_filter_enable=0, o_threshold=THRESH_RESET.
  - Flush FSM=IDLE; all edge and hold registers=0.
- Reset takes effect on the first i_sysclk edge with i_rstn=0. Reset mid-flush returns to IDLE with enables cleared.
- Latency from debounced edge:
  - o_mode: +2 cycles (edge flop plus update).
  - o_threshold: +2 cycles.
  - o_pipe_flush: +3 cycles from the debounced switch change.
- i_sof while IDLE has no effect, apart from re-loading the (unchanged) target.
- i_sof in the same cycle as the change detection: the FSM enters PENDING, and the change applies at the next i_sof.
- Saturation: at MAX, inc holds the value. At MIN, dec holds the value. A value within STEP of a bound clamps to that bound.

## Test plan
Bench parameters: DB_COUNT=4, REPEAT_DELAY=20, REPEAT_RATE=5, NUM_FILTERS=3, NUM_MODES=3, STEP=10, MIN=5, MAX=100, RESET=50.
- Reset release → o_cfg_start high exactly 1 cycle. All other outputs at their reset values. Threshold=50.
- Three mode presses → o_mode sequence 1, 2, 0. Each press also raises o_pipe_flush until the next i_sof.
- In mode 1, set sw=3'b101 mid-frame → o_filter_enable stays 0 and o_pipe_flush is high until i_sof. Then enables=3'b101 and flush drops in the same cycle. In mode 0, the same switches → enables stay 0.
- Inc pressed 6 times → 60, 70, 80, 90, 100, 100. Dec from 12 → 5, then stays 5.
- Inc held 32 cycles past debounce → steps at hold cycles 0, 20, 25, 30: 50→60→70→80→90. Release → no further steps.
- Inc and dec held together → threshold unchanged. Assert i_rstn=0 while PENDING → FSM IDLE, flush=0, enables=0 on the next edge.

Source files
------------

// File: rtl/pipe_control.sv
// Board-input front end for the camera pipeline: debounced buttons and switches become a mode,
// a saturating auto-repeat threshold and frame-aligned filter enables with a flush request.
module pipe_control #(
    parameter int NUM_FILTERS  = 2,
    parameter int NUM_MODES    = 2,
    parameter int THRESH_W     = 22,
    parameter int THRESH_RESET = 500000,
    parameter int THRESH_STEP  = 50000,
    parameter int THRESH_MIN   = 0,
    parameter int THRESH_MAX   = 2090000,
    parameter int DB_COUNT     = 500000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic                         i_sysclk,
    input  logic                         i_rstn,
    input  logic                         i_sof,
    input  logic                         i_btn_mode,
    input  logic                         i_btn_inc,
    input  logic                         i_btn_dec,
    input  logic [NUM_FILTERS-1:0]       i_sw_filter,
    output logic                         o_cfg_start,
    output logic [$clog2(NUM_MODES)-1:0] o_mode,
    output logic                         o_pipe_flush,
    output logic [NUM_FILTERS-1:0]       o_filter_enable,
    output logic [THRESH_W-1:0]          o_threshold
);
    localparam int MW  = $clog2(NUM_MODES);
    localparam int TW1 = THRESH_W + 1;
    localparam int HW  = $clog2(REPEAT_DELAY + 1);

    localparam logic [MW-1:0]  MODE_LAST    = MW'(NUM_MODES - 1);
    localparam logic [TW1-1:0] STEP_X       = TW1'(THRESH_STEP);
    localparam logic [TW1-1:0] MIN_X        = TW1'(THRESH_MIN);
    localparam logic [TW1-1:0] MAX_X        = TW1'(THRESH_MAX);
    localparam logic [TW1-1:0] LOW_X        = TW1'(THRESH_STEP + THRESH_MIN);
    localparam logic [HW-1:0]  HOLD_TOP     = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0]  HOLD_RESTART = HW'(REPEAT_DELAY - REPEAT_RATE + 1);

    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

    logic [2:0]             btn_db_s;
    logic [NUM_FILTERS-1:0] sw_db_s;
    logic [2:0]             btn_q_r;
    logic [NUM_FILTERS-1:0] sw_q_r;
    logic [NUM_FILTERS-1:0] target_r;
    logic                   mode_rise_r;
    logic                   mode_chg_r;
    logic                   started_r;
    logic [HW-1:0]          hold_inc_r;
    logic [HW-1:0]          hold_dec_r;
    state_t                 state_r;
    logic                   both_s;
    logic                   inc_held_s;
    logic                   dec_held_s;
    logic                   inc_step_s;
    logic                   dec_step_s;
    logic [TW1-1:0]         thr_ext_s;
    logic [TW1-1:0]         thr_up_s;
    logic [TW1-1:0]         thr_dn_s;

    // Hold counter restarts at zero whenever the button is not (solely) held; after the
    // initial delay it folds back so that every REPEAT_RATE cycles it lands on HOLD_TOP again.
    function automatic logic [HW-1:0] hold_next(input logic held, input logic [HW-1:0] cnt);
        if (!held) begin
            hold_next = '0;
        end else if (cnt == HOLD_TOP) begin
            hold_next = HOLD_RESTART;
        end else begin
            hold_next = cnt + HW'(1);
        end
    endfunction

    debounce #(.DB_COUNT(DB_COUNT)) u_db_mode (.clk(i_sysclk), .rstn(i_rstn), .din(i_btn_mode), .dout(btn_db_s[0]));
    debounce #(.DB_COUNT(DB_COUNT)) u_db_inc  (.clk(i_sysclk), .rstn(i_rstn), .din(i_btn_inc),  .dout(btn_db_s[1]));
    debounce #(.DB_COUNT(DB_COUNT)) u_db_dec  (.clk(i_sysclk), .rstn(i_rstn), .din(i_btn_dec),  .dout(btn_db_s[2]));

    for (genvar g = 0; g < NUM_FILTERS; g++) begin : g_sw
        debounce #(.DB_COUNT(DB_COUNT)) u_db_sw (
            .clk(i_sysclk), .rstn(i_rstn), .din(i_sw_filter[g]), .dout(sw_db_s[g])
        );
    end

    // Step decisions and saturating next-threshold candidates, widened by one bit.
    always_comb begin
        both_s     = btn_q_r[1] & btn_q_r[2];
        inc_held_s = btn_q_r[1] & ~both_s;
        dec_held_s = btn_q_r[2] & ~both_s;
        inc_step_s = inc_held_s & ((hold_inc_r == '0) | (hold_inc_r == HOLD_TOP));
        dec_step_s = dec_held_s & ((hold_dec_r == '0) | (hold_dec_r == HOLD_TOP));
        thr_ext_s  = {1'b0, o_threshold};
        thr_up_s   = ((thr_ext_s + STEP_X) > MAX_X) ? MAX_X : (thr_ext_s + STEP_X);
        thr_dn_s   = (thr_ext_s < LOW_X) ? MIN_X : (thr_ext_s - STEP_X);
    end

    // Edge flops, config start, mode counter and threshold with auto-repeat.
    always_ff @(posedge i_sysclk) begin
        if (!i_rstn) begin
            btn_q_r     <= 3'b000;
            sw_q_r      <= '0;
            mode_rise_r <= 1'b0;
            mode_chg_r  <= 1'b0;
            started_r   <= 1'b0;
            o_cfg_start <= 1'b0;
            o_mode      <= '0;
            hold_inc_r  <= '0;
            hold_dec_r  <= '0;
            o_threshold <= THRESH_W'(THRESH_RESET);
        end else begin
            btn_q_r     <= btn_db_s;
            sw_q_r      <= sw_db_s;
            mode_rise_r <= btn_db_s[0] & ~btn_q_r[0];
            mode_chg_r  <= mode_rise_r;
            started_r   <= 1'b1;
            o_cfg_start <= ~started_r;
            if (mode_rise_r) begin
                o_mode <= (o_mode == MODE_LAST) ? '0 : (o_mode + MW'(1));
            end
            hold_inc_r <= hold_next(inc_held_s, hold_inc_r);
            hold_dec_r <= hold_next(dec_held_s, hold_dec_r);
            if (inc_step_s) begin
                o_threshold <= thr_up_s[THRESH_W-1:0];
            end else if (dec_step_s) begin
                o_threshold <= thr_dn_s[THRESH_W-1:0];
            end
        end
    end

    // Flush FSM: enables only ever load on a start-of-frame so they never change mid-frame.
    always_ff @(posedge i_sysclk) begin
        if (!i_rstn) begin
            target_r        <= '0;
            state_r         <= IDLE;
            o_pipe_flush    <= 1'b0;
            o_filter_enable <= '0;
        end else begin
            target_r <= (o_mode == '0) ? '0 : sw_q_r;
            case (state_r)
                IDLE: begin
                    if ((target_r != o_filter_enable) || mode_chg_r) begin
                        state_r      <= PENDING;
                        o_pipe_flush <= 1'b1;
                    end else if (i_sof) begin
                        o_filter_enable <= target_r;
                    end
                end
                PENDING: begin
                    if (i_sof) begin
                        state_r         <= IDLE;
                        o_pipe_flush    <= 1'b0;
                        o_filter_enable <= target_r;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    o_pipe_flush <= 1'b0;
                end
            endcase
        end
    end
endmodule

// Output follows the input once it has disagreed for DB_COUNT consecutive cycles.
module debounce #(
    parameter int DB_COUNT = 500000
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic dout
);
    localparam int CW = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(DB_COUNT - 1);

    logic [CW-1:0] cnt_r;

    // Stability counter; any agreement with the current output restarts it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_r <= '0;
            dout  <= 1'b0;
        end else if (din == dout) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
            dout  <= din;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end
endmodule

// File: tb/tb_pipe_control.sv
// Randomised and directed stimulus for pipe_control, checked every cycle against a behavioural model.
module tb_pipe_control;
    localparam int DB = 4, RD = 20, RR = 5, STEP = 10, TMIN = 5, TMAX = 100, TRST = 50;

    logic        clk = 1'b0;
    logic        rstn, sof;
    logic [5:0]  raw;
    logic        cfg_start, flush;
    logic [1:0]  mode;
    logic [2:0]  fen;
    logic [21:0] thr;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    bit sof_auto = 0;

    // model state (raw bits: 0 mode, 1 inc, 2 dec, 5:3 switches)
    logic [5:0] m_db, m_dq;
    int         m_run[6];
    bit         m_mrise, m_mchg, m_pend, m_started, m_cfg;
    int         m_mode, m_thr, m_kinc, m_kdec;
    logic [2:0] m_target, m_en;

    always #5 clk = ~clk;

    pipe_control #(
        .NUM_FILTERS(3), .NUM_MODES(3), .THRESH_W(22), .THRESH_RESET(TRST),
        .THRESH_STEP(STEP), .THRESH_MIN(TMIN), .THRESH_MAX(TMAX),
        .DB_COUNT(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .i_sysclk(clk), .i_rstn(rstn), .i_sof(sof),
        .i_btn_mode(raw[0]), .i_btn_inc(raw[1]), .i_btn_dec(raw[2]),
        .i_sw_filter(raw[5:3]),
        .o_cfg_start(cfg_start), .o_mode(mode), .o_pipe_flush(flush),
        .o_filter_enable(fen), .o_threshold(thr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit repeat_due(input int k);
        return (k == 0) || (k >= RD && ((k - RD) % RR) == 0);
    endfunction

    // One clock of the specification's rules, all next values derived from the previous state.
    task automatic model_step();
        logic [5:0] n_db;
        int         n_run[6];
        int         n_mode, n_thr;
        bit         n_pend, both, inc_h, dec_h;
        logic [2:0] n_en, n_target;
        if (!rstn) begin
            m_db = '0; m_dq = '0; m_mrise = 0; m_mchg = 0; m_mode = 0;
            m_target = '0; m_pend = 0; m_en = '0; m_thr = TRST;
            m_kinc = 0; m_kdec = 0; m_started = 0; m_cfg = 0;
            for (int i = 0; i < 6; i++) m_run[i] = 0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_db[i] = m_db[i];
                n_run[i] = 0;
                if (raw[i] != m_db[i]) begin
                    if (m_run[i] + 1 == DB) n_db[i] = raw[i];
                    else n_run[i] = m_run[i] + 1;
                end
            end
            n_mode   = m_mrise ? (m_mode + 1) % 3 : m_mode;
            n_target = (m_mode == 0) ? 3'b000 : m_dq[5:3];
            n_pend = m_pend;
            n_en   = m_en;
            if (m_pend) begin
                if (sof) begin n_pend = 0; n_en = m_target; end
            end else if (m_target != m_en || m_mchg) begin
                n_pend = 1;
            end
            both  = m_dq[1] && m_dq[2];
            inc_h = m_dq[1] && !both;
            dec_h = m_dq[2] && !both;
            n_thr = m_thr;
            if (inc_h && repeat_due(m_kinc)) n_thr = (m_thr + STEP > TMAX) ? TMAX : m_thr + STEP;
            if (dec_h && repeat_due(m_kdec)) n_thr = (m_thr - STEP < TMIN) ? TMIN : m_thr - STEP;
            m_kinc = inc_h ? m_kinc + 1 : 0;
            m_kdec = dec_h ? m_kdec + 1 : 0;
            m_mchg  = m_mrise;
            m_mrise = m_db[0] && !m_dq[0];
            m_dq = m_db;
            m_db = n_db;
            for (int i = 0; i < 6; i++) m_run[i] = n_run[i];
            m_mode = n_mode; m_target = n_target; m_pend = n_pend; m_en = n_en; m_thr = n_thr;
            m_cfg = !m_started;
            m_started = 1;
        end
    endtask

    task automatic compare_all();
        check("cfg_start", {31'd0, cfg_start}, {31'd0, m_cfg});
        check("mode", {30'd0, mode}, m_mode);
        check("pipe_flush", {31'd0, flush}, {31'd0, m_pend});
        check("filter_enable", {29'd0, fen}, {29'd0, m_en});
        check("threshold", {10'd0, thr}, m_thr);
    endtask

    task automatic tick();
        if (sof_auto) sof = ((cyc % 16) == 15);
        cyc++;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic press(input int b, input int hi, input int lo);
        raw[b] = 1'b1;
        repeat (hi) tick();
        raw[b] = 1'b0;
        repeat (lo) tick();
    endtask

    initial begin
        int exp_m[3] = '{1, 2, 0};
        rstn = 1'b0; sof = 1'b0; raw = 6'd0;
        @(negedge clk);
        repeat (3) tick();
        check("reset_threshold", {10'd0, thr}, 32'd50);
        check("reset_cfg_start", {31'd0, cfg_start}, 32'd0);
        rstn = 1'b1;
        tick();
        check("cfg_start_pulse", {31'd0, cfg_start}, 32'd1);
        tick();
        check("cfg_start_low", {31'd0, cfg_start}, 32'd0);

        sof_auto = 1;
        for (int i = 0; i < 3; i++) begin
            press(0, 8, 24);
            check("mode_sequence", {30'd0, mode}, exp_m[i]);
        end
        press(0, 8, 24);
        check("mode_one", {30'd0, mode}, 32'd1);

        sof_auto = 0; sof = 1'b0;
        raw[5:3] = 3'b101;
        repeat (12) tick();
        check("enable_held_midframe", {29'd0, fen}, 32'd0);
        check("flush_pending", {31'd0, flush}, 32'd1);
        sof = 1'b1;
        tick();
        sof = 1'b0;
        check("enable_at_sof", {29'd0, fen}, 32'd5);
        check("flush_drop_at_sof", {31'd0, flush}, 32'd0);

        sof_auto = 1;
        press(0, 8, 24);
        press(0, 8, 24);
        check("mode_zero_enables", {29'd0, fen}, 32'd0);
        raw[5:3] = 3'b000;
        repeat (24) tick();

        for (int i = 0; i < 6; i++) begin
            press(1, 8, 8);
            check("inc_press", {10'd0, thr}, (60 + 10 * i > 100) ? 100 : 60 + 10 * i);
        end
        for (int i = 0; i < 10; i++) begin
            press(2, 8, 8);
            check("dec_press", {10'd0, thr}, (90 - 10 * i < 5) ? 5 : 90 - 10 * i);
        end
        press(1, 33, 12);
        check("inc_autorepeat", {10'd0, thr}, 32'd45);

        raw[2:1] = 2'b11;
        repeat (30) tick();
        raw[2:1] = 2'b00;
        repeat (12) tick();
        check("inc_dec_together", {10'd0, thr}, 32'd45);

        sof_auto = 0; sof = 1'b0;
        press(0, 8, 0);
        check("flush_before_reset", {31'd0, flush}, 32'd1);
        rstn = 1'b0;
        tick();
        check("reset_flush", {31'd0, flush}, 32'd0);
        check("reset_enable", {29'd0, fen}, 32'd0);
        check("reset_mode", {30'd0, mode}, 32'd0);
        rstn = 1'b1;
        tick();

        for (int n = 0; n < 4000; n++) begin
            for (int b = 0; b < 6; b++) begin
                if ($urandom_range(0, 29) == 0) raw[b] = ~raw[b];
            end
            sof  = ($urandom_range(0, 9) == 0);
            rstn = ($urandom_range(0, 799) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
